// File: rtl/grf_wb_sched.sv
// Single-write-port GRF scheduler: W-stage write wins, long-latency results queue in a FIFO, zero-latency port select.
// Long-latency producers are backpressured via lu_ack; a busy scoreboard stalls D-stage readers and WAW issue.
module grf_wb_sched #(
  parameter int DEPTH = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pipe_we,
  input  logic [AW-1:0]           pipe_rw,
  input  logic [DW-1:0]           pipe_wd,
  input  logic                    lu_req,
  input  logic [AW-1:0]           lu_rw,
  input  logic [DW-1:0]           lu_wd,
  output logic                    lu_ack,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rw,
  input  logic [AW-1:0]           rs,
  input  logic [AW-1:0]           rt,
  output logic                    stall,
  output logic                    grf_we,
  output logic [AW-1:0]           grf_rw,
  output logic [DW-1:0]           grf_wd,
  output logic [$clog2(DEPTH):0]  fifo_cnt,
  output logic                    conflict_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 1 << AW;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DW-1:0]  wd_q [DEPTH];
  logic [AW-1:0]  rw_q [DEPTH];
  logic [PW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NR-1:0]  busy_q, busy_d;
  logic           err_q, err_d;

  logic           pipe_win, pop, push, iss_set;
  logic           rs_hold, rt_hold, waw_hold;
  logic [AW-1:0]  head_rw;
  logic [DW-1:0]  head_wd;

  assign head_rw = rw_q[rptr_q];
  assign head_wd = wd_q[rptr_q];

  assign pipe_win = ~reset & pipe_we & (pipe_rw != '0);
  assign pop      = ~reset & ~pipe_win & (cnt_q != '0);
  assign lu_ack   = ~reset & lu_req & ((cnt_q < FULL) | pop);
  assign push     = lu_ack & (lu_rw != '0);

  // A source being popped this cycle is forwarded by the register file, so it need not stall.
  assign rs_hold  = (rs != '0) & busy_q[rs] & ~(pop & (head_rw == rs));
  assign rt_hold  = (rt != '0) & busy_q[rt] & ~(pop & (head_rw == rt));
  assign waw_hold = iss_valid & (iss_rw != '0) & busy_q[iss_rw];
  assign stall    = ~reset & (rs_hold | rt_hold | waw_hold);
  assign iss_set  = ~reset & iss_valid & (iss_rw != '0) & ~stall;

  always_comb begin
    grf_we = 1'b0;
    grf_rw = '0;
    grf_wd = '0;
    if (pipe_win) begin
      grf_we = 1'b1;
      grf_rw = pipe_rw;
      grf_wd = pipe_wd;
    end else if (pop) begin
      grf_we = 1'b1;
      grf_rw = head_rw;
      grf_wd = head_wd;
    end
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear before set so a same-cycle reissue of the popped register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (pop)     busy_d[head_rw] = 1'b0;
    if (iss_set) busy_d[iss_rw]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (pipe_win & busy_q[pipe_rw])                     err_d = 1'b1;
    if (lu_ack & (lu_rw != '0) & ~busy_q[lu_rw])        err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      wd_q[wptr_q] <= lu_wd;
      rw_q[wptr_q] <= lu_rw;
    end
  end

  assign fifo_cnt     = cnt_q;
  assign conflict_err = err_q;

endmodule

// File: tb/tb_grf_wb_sched.sv
// Directed bench for grf_wb_sched: expected long-latency writes are queued when driven and matched on the port.
module tb_grf_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_rw;
  logic [31:0] pipe_wd;
  logic        lu_req;
  logic [4:0]  lu_rw;
  logic [31:0] lu_wd;
  logic        lu_ack;
  logic        iss_valid;
  logic [4:0]  iss_rw;
  logic [4:0]  rs, rt;
  logic        stall;
  logic        grf_we;
  logic [4:0]  grf_rw;
  logic [31:0] grf_wd;
  logic [1:0]  fifo_cnt;
  logic        conflict_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  grf_wb_sched #(.DEPTH(2), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_rw(pipe_rw), .pipe_wd(pipe_wd),
    .lu_req(lu_req), .lu_rw(lu_rw), .lu_wd(lu_wd), .lu_ack(lu_ack),
    .iss_valid(iss_valid), .iss_rw(iss_rw), .rs(rs), .rt(rt), .stall(stall),
    .grf_we(grf_we), .grf_rw(grf_rw), .grf_wd(grf_wd),
    .fifo_cnt(fifo_cnt), .conflict_err(conflict_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every port write is matched: W-stage writes against the driven inputs, others against the queue head.
  task automatic monitor();
    wr_t e;
    if (grf_we === 1'b1) begin
      if (pipe_we && pipe_rw != 5'd0) begin
        chk("pipe_rw", 32'(grf_rw), 32'(pipe_rw));
        chk("pipe_wd", grf_wd, pipe_wd);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_spurious observed write rw=%0d expected none", grf_rw);
      end else begin
        e = exp_q.pop_front();
        chk("sb_rw", 32'(grf_rw), 32'(e.rw));
        chk("sb_wd", grf_wd, e.wd);
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    monitor();
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_drive(input logic [4:0] rw, input logic [31:0] wd, input bit expect_write);
    wr_t e;
    lu_req = 1'b1;
    lu_rw  = rw;
    lu_wd  = wd;
    e.rw = rw;
    e.wd = wd;
    if (expect_write) exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b1; pipe_we = 1'b1; pipe_rw = 5'd8; pipe_wd = 32'h1;
    lu_req = 1'b1; lu_rw = 5'd4; lu_wd = 32'h0;
    iss_valid = 1'b0; iss_rw = 5'd0; rs = 5'd0; rt = 5'd0;
    half();
    chk("rst_grf_we", 32'(grf_we), 32'd0);
    chk("rst_lu_ack", 32'(lu_ack), 32'd0);
    chk("rst_stall",  32'(stall),  32'd0);
    edge_();
    edge_();
    reset = 1'b0; pipe_we = 1'b0; lu_req = 1'b0;
    half();
    chk("rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("rst_err", 32'(conflict_err), 32'd0);
    chk("idle_grf_we", 32'(grf_we), 32'd0);
    edge_();

    // Direct pipe write, zero latency
    pipe_we = 1'b1; pipe_rw = 5'd8; pipe_wd = 32'h1234;
    half();
    chk("pipe_we_out", 32'(grf_we), 32'd1);
    chk("pipe_rw_out", 32'(grf_rw), 32'd8);
    chk("pipe_wd_out", grf_wd, 32'h1234);
    chk("pipe_cnt", 32'(fifo_cnt), 32'd0);
    edge_();
    pipe_we = 1'b0;

    // Issue r9, reader stalls until the pop cycle
    iss_valid = 1'b1; iss_rw = 5'd9;
    half();
    chk("iss9_stall", 32'(stall), 32'd0);
    edge_();
    iss_valid = 1'b0; rs = 5'd9;
    half();
    chk("rs9_stall_busy", 32'(stall), 32'd1);
    edge_();
    lu_drive(5'd9, 32'hAB, 1'b1);
    half();
    chk("lu9_ack", 32'(lu_ack), 32'd1);
    chk("lu9_stall", 32'(stall), 32'd1);
    chk("lu9_grf_we", 32'(grf_we), 32'd0);
    edge_();
    lu_req = 1'b0;
    half();
    chk("pop9_we", 32'(grf_we), 32'd1);
    chk("pop9_rw", 32'(grf_rw), 32'd9);
    chk("pop9_stall_exempt", 32'(stall), 32'd0);
    chk("pop9_cnt", 32'(fifo_cnt), 32'd1);
    edge_();
    half();
    chk("post9_stall", 32'(stall), 32'd0);
    chk("post9_cnt", 32'(fifo_cnt), 32'd0);
    edge_();
    rs = 5'd0;

    // Pipe holds the port while two results fill the FIFO
    iss_valid = 1'b1; iss_rw = 5'd5; edge_();
    iss_rw = 5'd6; edge_();
    iss_rw = 5'd11; edge_();
    iss_valid = 1'b0;
    pipe_we = 1'b1; pipe_rw = 5'd3; pipe_wd = 32'h3333;
    lu_drive(5'd5, 32'h55, 1'b1);
    half();
    chk("lu5_ack", 32'(lu_ack), 32'd1);
    edge_();
    lu_drive(5'd6, 32'h66, 1'b1);
    half();
    chk("lu6_ack", 32'(lu_ack), 32'd1);
    chk("lu6_cnt", 32'(fifo_cnt), 32'd1);
    edge_();
    lu_drive(5'd11, 32'hBB, 1'b1);
    half();
    chk("full_cnt", 32'(fifo_cnt), 32'd2);
    chk("full_noack", 32'(lu_ack), 32'd0);
    edge_();
    half();
    chk("full_noack2", 32'(lu_ack), 32'd0);
    chk("full_cnt2", 32'(fifo_cnt), 32'd2);
    edge_();
    pipe_we = 1'b0;
    half();
    chk("drain5_rw", 32'(grf_rw), 32'd5);
    chk("pushpop_ack", 32'(lu_ack), 32'd1);
    edge_();
    lu_req = 1'b0;
    half();
    chk("drain6_rw", 32'(grf_rw), 32'd6);
    chk("pushpop_cnt", 32'(fifo_cnt), 32'd2);
    edge_();
    half();
    chk("drain11_rw", 32'(grf_rw), 32'd11);
    chk("drain_cnt1", 32'(fifo_cnt), 32'd1);
    edge_();
    half();
    chk("drain_cnt0", 32'(fifo_cnt), 32'd0);
    chk("drain_err", 32'(conflict_err), 32'd0);
    edge_();

    // WAW on r10
    iss_valid = 1'b1; iss_rw = 5'd10;
    edge_();
    half();
    chk("waw_stall", 32'(stall), 32'd1);
    edge_();
    lu_drive(5'd10, 32'h10, 1'b1);
    half();
    chk("waw_stall2", 32'(stall), 32'd1);
    chk("lu10_ack", 32'(lu_ack), 32'd1);
    edge_();
    lu_req = 1'b0;
    half();
    chk("pop10_rw", 32'(grf_rw), 32'd10);
    chk("pop10_waw_stall", 32'(stall), 32'd1);
    edge_();
    half();
    chk("reissue_ok", 32'(stall), 32'd0);
    edge_();
    half();
    chk("reissue_set", 32'(stall), 32'd1);
    edge_();
    iss_valid = 1'b0;

    // Register-0 traffic
    lu_drive(5'd0, 32'hDEAD, 1'b0);
    half();
    chk("lu0_ack", 32'(lu_ack), 32'd1);
    chk("lu0_we", 32'(grf_we), 32'd0);
    edge_();
    lu_req = 1'b0;
    half();
    chk("lu0_cnt", 32'(fifo_cnt), 32'd0);
    chk("lu0_we2", 32'(grf_we), 32'd0);
    edge_();
    pipe_we = 1'b1; pipe_rw = 5'd4; pipe_wd = 32'h4;
    lu_drive(5'd10, 32'hA0, 1'b1);
    half();
    chk("lu10b_ack", 32'(lu_ack), 32'd1);
    edge_();
    lu_req = 1'b0; pipe_rw = 5'd0; pipe_wd = 32'hFFFF;
    half();
    chk("pipe0_head_we", 32'(grf_we), 32'd1);
    chk("pipe0_head_rw", 32'(grf_rw), 32'd10);
    chk("pipe0_head_wd", grf_wd, 32'hA0);
    edge_();
    pipe_we = 1'b0;
    half();
    chk("pipe0_cnt", 32'(fifo_cnt), 32'd0);
    chk("pre_conf_err", 32'(conflict_err), 32'd0);
    edge_();

    // Conflict on busy r7, then reset with a full FIFO
    iss_valid = 1'b1; iss_rw = 5'd7; edge_();
    iss_rw = 5'd12; edge_();
    iss_rw = 5'd13; edge_();
    iss_valid = 1'b0;
    pipe_we = 1'b1; pipe_rw = 5'd7; pipe_wd = 32'h77;
    half();
    chk("conf_pipe_rw", 32'(grf_rw), 32'd7);
    edge_();
    pipe_rw = 5'd3;
    half();
    chk("conf_err_set", 32'(conflict_err), 32'd1);
    edge_();
    lu_drive(5'd12, 32'hC12, 1'b1);
    edge_();
    lu_drive(5'd13, 32'hC13, 1'b1);
    edge_();
    lu_req = 1'b0;
    half();
    chk("conf_err_held", 32'(conflict_err), 32'd1);
    chk("prerst_cnt", 32'(fifo_cnt), 32'd2);
    edge_();
    exp_q.delete();
    reset = 1'b1; pipe_we = 1'b0; rs = 5'd12; rt = 5'd13;
    lu_drive(5'd14, 32'hE14, 1'b0);
    half();
    chk("mid_rst_we", 32'(grf_we), 32'd0);
    chk("mid_rst_ack", 32'(lu_ack), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    edge_();
    reset = 1'b0; iss_valid = 1'b1; iss_rw = 5'd7;
    half();
    chk("post_rst_cnt", 32'(fifo_cnt), 32'd0);
    chk("post_rst_err", 32'(conflict_err), 32'd0);
    chk("post_rst_busy", 32'(stall), 32'd0);
    chk("post_rst_we", 32'(grf_we), 32'd0);
    chk("post_rst_newreq", 32'(lu_ack), 32'd1);
    lu_drive(5'd14, 32'hE14, 1'b1);
    edge_();
    lu_req = 1'b0; iss_valid = 1'b0; rs = 5'd0; rt = 5'd0;
    half();
    chk("orphan_err", 32'(conflict_err), 32'd1);
    chk("orphan_rw", 32'(grf_rw), 32'd14);
    edge_();
    half();
    chk("end_cnt", 32'(fifo_cnt), 32'd0);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
